// File: rtl/signed_divider_pkg.sv
// rtl/signed_divider_pkg.sv - shared constants, state type and saturation helpers for signed_divider
package signed_divider_pkg;

  localparam int DW_DEFAULT = 19;
  localparam int N_ITER     = 2 * DW_DEFAULT - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Largest positive w-bit two's-complement value, zero-extended to 64 bits.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Bit pattern of the most negative w-bit value; also the magnitude of that value.
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

  localparam logic [DW_DEFAULT-1:0] QMAX = DW_DEFAULT'(sat_max(DW_DEFAULT));
  localparam logic [DW_DEFAULT-1:0] QMIN = DW_DEFAULT'(sat_min(DW_DEFAULT));

endpackage

// File: rtl/signed_divider_div_step.sv
// rtl/signed_divider_div_step.sv - one restoring shift/compare/subtract iteration
//   partial      : current partial remainder (DW+1 bits)
//   next_bit     : next dividend bit, MSB first
//   divisor      : divisor magnitude
//   partial_next : partial remainder after this iteration
//   q_bit        : quotient bit produced by this iteration
module div_step #(
  parameter int DW = 19
) (
  input  logic [DW:0]   partial,
  input  logic          next_bit,
  input  logic [DW-1:0] divisor,
  output logic [DW:0]   partial_next,
  output logic          q_bit
);

  logic [DW+1:0] shifted;
  logic [DW+1:0] diff;

  // shifted stays below 2^(DW+1) and divisor below 2^DW, so the top bit of
  // the difference is a clean borrow flag: clear means shifted >= divisor.
  always_comb begin
    shifted      = {partial, next_bit};
    diff         = shifted - {2'b00, divisor};
    q_bit        = ~diff[DW+1];
    partial_next = q_bit ? diff[DW:0] : shifted[DW:0];
  end

endmodule

// File: rtl/signed_divider.sv
// rtl/signed_divider.sv - sequential signed divider, (2*DW-1)-bit dividend by DW-bit divisor
//   Clk, Reset      : rising-edge clock, synchronous active-high reset
//   Start           : request, sampled only while idle
//   A, B            : dividend (2*DW-1 bits) and divisor (DW bits), two's complement
//   Busy, Valid     : operation in flight / one-cycle result strobe
//   Q, R            : saturated quotient and remainder, held until the next result
//   Overflow        : true quotient did not fit DW signed bits
//   DivZero         : divisor was zero
module signed_divider
  import signed_divider_pkg::*;
#(
  parameter int DW = signed_divider_pkg::DW_DEFAULT
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [2*DW-2:0] A,
  input  logic [DW-1:0]   B,
  output logic            Busy,
  output logic            Valid,
  output logic [DW-1:0]   Q,
  output logic [DW-1:0]   R,
  output logic            Overflow,
  output logic            DivZero
);

  localparam int AW = 2 * DW - 1;
  localparam int CW = $clog2(AW);
  localparam logic [CW-1:0] LAST_CNT = CW'(AW - 1);

  localparam logic [DW-1:0] Q_MAX   = DW'(sat_max(DW));
  localparam logic [DW-1:0] Q_MIN   = DW'(sat_min(DW));
  // Quotient-magnitude limits: positive results may reach 2^(DW-1)-1,
  // negative results one further, to 2^(DW-1).
  localparam logic [AW-1:0] POS_LIM = AW'(sat_max(DW));
  localparam logic [AW-1:0] NEG_LIM = AW'(sat_min(DW));

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] dvd;
  logic [AW-1:0] quo;
  logic [DW:0]   part;
  logic [DW:0]   part_next;
  logic [DW-1:0] dsr;
  logic          s_a;
  logic          s_b;
  logic          dz;
  logic          q_bit;

  logic [DW-1:0] fix_q;
  logic [DW-1:0] fix_r;
  logic          fix_ovf;

  div_step #(.DW(DW)) u_step (
    .partial      (part),
    .next_bit     (dvd[AW-1]),
    .divisor      (dsr),
    .partial_next (part_next),
    .q_bit        (q_bit)
  );

  // Sign application and saturation of the finished magnitudes.
  always_comb begin
    fix_q   = '0;
    fix_r   = '0;
    fix_ovf = 1'b0;
    if (dz) begin
      fix_q = s_a ? Q_MIN : Q_MAX;
    end else begin
      if (s_a ^ s_b) begin
        if (quo > NEG_LIM) begin
          fix_q   = Q_MIN;
          fix_ovf = 1'b1;
        end else begin
          fix_q = -quo[DW-1:0];
        end
      end else begin
        if (quo > POS_LIM) begin
          fix_q   = Q_MAX;
          fix_ovf = 1'b1;
        end else begin
          fix_q = quo[DW-1:0];
        end
      end
      // Remainder magnitude is below |B| <= 2^(DW-1), so DW bits suffice.
      fix_r = s_a ? -part[DW-1:0] : part[DW-1:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      Busy     <= 1'b0;
      Valid    <= 1'b0;
      Q        <= '0;
      R        <= '0;
      Overflow <= 1'b0;
      DivZero  <= 1'b0;
    end else begin
      Valid <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            s_a   <= A[AW-1];
            s_b   <= B[DW-1];
            // Unsigned magnitudes keep the most negative operands representable.
            dvd   <= A[AW-1] ? -A : A;
            dsr   <= B[DW-1] ? -B : B;
            dz    <= (B == '0);
            part  <= '0;
            quo   <= '0;
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= DIV;
          end
        end
        DIV: begin
          // Divide-by-zero runs the full loop too so latency never varies.
          part <= part_next;
          quo  <= {quo[AW-2:0], q_bit};
          dvd  <= {dvd[AW-2:0], 1'b0};
          cnt  <= cnt + CW'(1);
          if (cnt == LAST_CNT) begin
            state <= FIX;
          end
        end
        FIX: begin
          Q        <= fix_q;
          R        <= fix_r;
          Overflow <= fix_ovf;
          DivZero  <= dz;
          Valid    <= 1'b1;
          Busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_divider.sv
// tb/tb_signed_divider.sv - directed and factor-product checks of signed_divider
module tb_signed_divider;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [36:0] A = '0;
  logic [18:0] B = '0;
  logic        Busy;
  logic        Valid;
  logic [18:0] Q;
  logic [18:0] R;
  logic        Overflow;
  logic        DivZero;

  int n_vec = 0;
  int n_err = 0;

  signed_divider #(.DW(19)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .A        (A),
    .B        (B),
    .Busy     (Busy),
    .Valid    (Valid),
    .Q        (Q),
    .R        (R),
    .Overflow (Overflow),
    .DivZero  (DivZero)
  );

  always #5 Clk = ~Clk;

  // Launches one division and waits (bounded) for Valid; lat = -1 on timeout.
  task automatic run_div(input logic [36:0] a, input logic [18:0] b, input bit sync,
                         output int lat, output bit busy_bad);
    busy_bad = 1'b0;
    if (sync) @(negedge Clk);
    A = a; B = b; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    if (!Busy) busy_bad = 1'b1;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge Clk); #1;
      if (Valid) begin
        lat = i;
        break;
      end
      if (!Busy) busy_bad = 1'b1;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    n_vec++; if (Busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy got %b exp 0", Busy); end
    n_vec++; if (Valid !== 1'b0)    begin n_err++; $display("FAIL reset_valid got %b exp 0", Valid); end
    n_vec++; if (Q !== 19'd0)       begin n_err++; $display("FAIL reset_q got %h exp 0", Q); end
    n_vec++; if (R !== 19'd0)       begin n_err++; $display("FAIL reset_r got %h exp 0", R); end
    n_vec++; if (Overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b exp 0", Overflow); end
    n_vec++; if (DivZero !== 1'b0)  begin n_err++; $display("FAIL reset_dz got %b exp 0", DivZero); end
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat; bit bb;
    run_div(37'd100, 19'd7, 1'b1, lat, bb);
    n_vec++; if (lat !== 38)        begin n_err++; $display("FAIL basic_latency got %0d exp 38", lat); end
    n_vec++; if (bb !== 1'b0)       begin n_err++; $display("FAIL basic_busy_gap got %b exp 0", bb); end
    n_vec++; if (Busy !== 1'b0)     begin n_err++; $display("FAIL basic_busy_at_valid got %b exp 0", Busy); end
    n_vec++; if ($signed(Q) !== 19'sd14) begin n_err++; $display("FAIL basic_q got %0d exp 14", $signed(Q)); end
    n_vec++; if ($signed(R) !== 19'sd2)  begin n_err++; $display("FAIL basic_r got %0d exp 2", $signed(R)); end
    n_vec++; if ({Overflow, DivZero} !== 2'b00) begin n_err++; $display("FAIL basic_flags got %b exp 00", {Overflow, DivZero}); end
    @(posedge Clk); #1;
    n_vec++; if (Valid !== 1'b0)    begin n_err++; $display("FAIL basic_valid_width got %b exp 0", Valid); end
    n_vec++; if ($signed(Q) !== 19'sd14) begin n_err++; $display("FAIL basic_q_hold got %0d exp 14", $signed(Q)); end
  endtask

  task automatic test_signs();
    logic signed [36:0] ta [4] = '{37'sd100, -37'sd100, 37'sd100, -37'sd100};
    logic signed [18:0] tb [4] = '{19'sd7, 19'sd7, -19'sd7, -19'sd7};
    logic signed [18:0] tq [4] = '{19'sd14, -19'sd14, -19'sd14, 19'sd14};
    logic signed [18:0] tr [4] = '{19'sd2, -19'sd2, 19'sd2, -19'sd2};
    int lat; bit bb;
    for (int i = 0; i < 4; i++) begin
      run_div(ta[i], tb[i], 1'b1, lat, bb);
      n_vec++; if (lat !== 38) begin n_err++; $display("FAIL signs%0d_latency got %0d exp 38", i, lat); end
      n_vec++; if ($signed(Q) !== tq[i]) begin n_err++; $display("FAIL signs%0d_q got %0d exp %0d", i, $signed(Q), tq[i]); end
      n_vec++; if ($signed(R) !== tr[i]) begin n_err++; $display("FAIL signs%0d_r got %0d exp %0d", i, $signed(R), tr[i]); end
      n_vec++; if ({Overflow, DivZero} !== 2'b00) begin n_err++; $display("FAIL signs%0d_flags got %b exp 00", i, {Overflow, DivZero}); end
    end
  endtask

  task automatic test_saturation();
    logic [36:0] ta [2] = '{37'h10_0000_0000, 37'h1F_FFEC_0000};  // -2^36, -1310720
    logic [18:0] tb [2] = '{19'h40000, 19'd5};                    // -2^18, 5
    logic [18:0] tq [2] = '{19'h3FFFF, 19'h40000};                // 262143, -262144
    logic        to [2] = '{1'b1, 1'b0};
    int lat; bit bb;
    for (int i = 0; i < 2; i++) begin
      run_div(ta[i], tb[i], 1'b1, lat, bb);
      n_vec++; if (lat !== 38) begin n_err++; $display("FAIL sat%0d_latency got %0d exp 38", i, lat); end
      n_vec++; if (Q !== tq[i]) begin n_err++; $display("FAIL sat%0d_q got %0d exp %0d", i, $signed(Q), $signed(tq[i])); end
      n_vec++; if (Overflow !== to[i]) begin n_err++; $display("FAIL sat%0d_ovf got %b exp %b", i, Overflow, to[i]); end
      n_vec++; if (R !== 19'd0) begin n_err++; $display("FAIL sat%0d_r got %0d exp 0", i, $signed(R)); end
    end
  endtask

  task automatic test_divzero();
    logic [36:0] ta [2] = '{37'h1F_FFFF_FFFF, 37'd5};  // -1, 5
    logic [18:0] tq [2] = '{19'h40000, 19'h3FFFF};
    int lat; bit bb;
    for (int i = 0; i < 2; i++) begin
      run_div(ta[i], 19'd0, 1'b1, lat, bb);
      n_vec++; if (lat !== 38) begin n_err++; $display("FAIL dz%0d_latency got %0d exp 38", i, lat); end
      n_vec++; if (Q !== tq[i]) begin n_err++; $display("FAIL dz%0d_q got %0d exp %0d", i, $signed(Q), $signed(tq[i])); end
      n_vec++; if (R !== 19'd0) begin n_err++; $display("FAIL dz%0d_r got %0d exp 0", i, $signed(R)); end
      n_vec++; if ({Overflow, DivZero} !== 2'b01) begin n_err++; $display("FAIL dz%0d_flags got %b exp 01", i, {Overflow, DivZero}); end
    end
  endtask

  task automatic test_start_ignored();
    int lat = -1;
    int extra = 0;
    @(negedge Clk);
    A = 37'd1000; B = -19'sd3; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      if (i == 5) begin A = 37'd77; B = 19'd11; Start = 1'b1; end
      @(posedge Clk); #1;
      Start = 1'b0;
      if (Valid) begin lat = i; break; end
    end
    n_vec++; if (lat !== 38) begin n_err++; $display("FAIL ignore_latency got %0d exp 38", lat); end
    n_vec++; if ($signed(Q) !== -19'sd333) begin n_err++; $display("FAIL ignore_q got %0d exp -333", $signed(Q)); end
    n_vec++; if ($signed(R) !== 19'sd1) begin n_err++; $display("FAIL ignore_r got %0d exp 1", $signed(R)); end
    for (int i = 0; i < 45; i++) begin
      @(posedge Clk); #1;
      if (Valid) extra++;
    end
    n_vec++; if (extra !== 0) begin n_err++; $display("FAIL ignore_no_second got %0d exp 0", extra); end
  endtask

  task automatic test_reset_midway();
    int lat; bit bb;
    int stray = 0;
    @(negedge Clk);
    A = 37'd100; B = 19'd7; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (9) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b exp 0", Busy); end
    n_vec++; if (Valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b exp 0", Valid); end
    n_vec++; if ({Q, R, Overflow, DivZero} !== 40'd0) begin n_err++; $display("FAIL midrst_outputs got %h exp 0", {Q, R, Overflow, DivZero}); end
    run_div(-37'sd100, -19'sd7, 1'b0, lat, bb);
    n_vec++; if (lat !== 38) begin n_err++; $display("FAIL postrst_latency got %0d exp 38", lat); end
    n_vec++; if ($signed(Q) !== 19'sd14) begin n_err++; $display("FAIL postrst_q got %0d exp 14", $signed(Q)); end
    n_vec++; if ($signed(R) !== -19'sd2) begin n_err++; $display("FAIL postrst_r got %0d exp -2", $signed(R)); end
    @(negedge Clk);
    Reset = 1'b1; Start = 1'b1; A = 37'd9; B = 19'd3;
    @(posedge Clk); #1;
    Reset = 1'b0; Start = 1'b0;
    n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL rst_priority_busy got %b exp 0", Busy); end
    for (int i = 0; i < 45; i++) begin
      @(posedge Clk); #1;
      if (Valid) stray++;
    end
    n_vec++; if (stray !== 0) begin n_err++; $display("FAIL rst_priority_valid got %0d exp 0", stray); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2; bit bb;
    run_div(37'd100, 19'd7, 1'b1, lat1, bb);
    n_vec++; if ($signed(Q) !== 19'sd14) begin n_err++; $display("FAIL b2b_q1 got %0d exp 14", $signed(Q)); end
    run_div(-37'sd1000, 19'sd3, 1'b0, lat2, bb);
    n_vec++; if (lat1 !== 38 || lat2 !== 38) begin n_err++; $display("FAIL b2b_latency got %0d/%0d exp 38/38", lat1, lat2); end
    n_vec++; if ($signed(Q) !== -19'sd333) begin n_err++; $display("FAIL b2b_q2 got %0d exp -333", $signed(Q)); end
    n_vec++; if ($signed(R) !== -19'sd1) begin n_err++; $display("FAIL b2b_r2 got %0d exp -1", $signed(R)); end
  endtask

  // A is built as x*y, so dividing by x must give exactly y with zero remainder.
  task automatic test_random_products();
    logic signed [18:0] x, y;
    longint p;
    int lat; bit bb;
    for (int i = 0; i < 150; i++) begin
      case (i)
        0: begin x = -19'sd262144; y = 19'sd262143; end
        1: begin x = 19'sd262143; y = -19'sd262144; end
        2: begin x = -19'sd1; y = -19'sd262144; end
        3: begin x = 19'sd1; y = 19'sd0; end
        default: begin
          x = 19'($urandom);
          while (x == 0) x = 19'($urandom);
          y = 19'($urandom);
          if (x == -19'sd262144 && y == -19'sd262144) y = 19'sd1;
        end
      endcase
      p = longint'(x) * longint'(y);
      run_div(p[36:0], x, 1'b1, lat, bb);
      n_vec++;
      if (lat !== 38 || Q !== y || R !== 19'd0 || {Overflow, DivZero} !== 2'b00) begin
        n_err++;
        $display("FAIL rand%0d x=%0d y=%0d got q=%0d r=%0d flags=%b lat=%0d exp q=%0d r=0 flags=00 lat=38",
                 i, x, y, $signed(Q), $signed(R), {Overflow, DivZero}, lat, y);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_saturation();
    test_divzero();
    test_start_ignored();
    test_reset_midway();
    test_back_to_back();
    test_random_products();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
